// File: rtl/ultrasonic_echo_model.sv
// Ultrasonic ranging target model (HC-SR04 style).
// Takes a trigger pulse and, after a fixed burst delay, answers with an echo
// pulse whose width encodes the programmed distance. Intended for
// hardware-in-the-loop bring-up and self-test of a distance-sensor block.
module ultrasonic_echo_model #(
  parameter int unsigned CLK_PER_US  = 100,
  parameter int unsigned MIN_TRIG_US = 10,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned US_PER_CM   = 58,
  parameter int unsigned DIST_MAX_CM = 400,
  parameter int unsigned MAX_ECHO_US = 38000,
  parameter int unsigned HOLDOFF_US  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [15:0] dist_cm,
  output logic        echo,
  output logic        busy,
  output logic [7:0]  trig_count,
  output logic        short_trig
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned UW = 16;
  localparam int unsigned EW = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          trig_s1;
  logic          trig_s2;
  logic          trig_d;
  logic          trig_rise;
  logic          trig_fall;

  logic [PW-1:0] presc;
  logic [UW-1:0] us_cnt;
  logic          tick;
  logic [EW-1:0] us_next;

  logic [15:0]   dist_q;
  logic [EW-1:0] echo_us;
  logic [EW-1:0] echo_width_c;

  logic          trig_long;
  logic          accept_c;
  logic          reject_c;
  logic          load_echo_c;

  // Edges are taken on the synchronized copy, so they lag trig by two cycles.
  assign trig_rise = trig_s2 & ~trig_d;
  assign trig_fall = ~trig_s2 & trig_d;

  // One-microsecond strobe from the prescaler.
  assign tick = (presc == PW'(CLK_PER_US - 1));

  // Microseconds elapsed once the current tick is included; a phase of N us
  // ends on the tick that brings this to N.
  assign us_next = EW'(us_cnt) + EW'(1);

  // Trigger high time qualification, using the count reached before the fall.
  assign trig_long = (EW'(us_cnt) >= MIN_TRIG_US);

  // Echo width in us for the latched distance; out-of-range reads as no object.
  always_comb begin
    echo_width_c = MAX_ECHO_US;
    if ((dist_q != 16'd0) && (EW'(dist_q) <= DIST_MAX_CM)) begin
      echo_width_c = EW'(dist_q) * US_PER_CM;
    end
  end

  // Next-state and single-cycle control strobes.
  always_comb begin
    state_next  = state;
    accept_c    = 1'b0;
    reject_c    = 1'b0;
    load_echo_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig_rise) begin
          state_next = S_TRIG;
        end
      end
      S_TRIG: begin
        if (trig_fall) begin
          if (trig_long) begin
            accept_c   = 1'b1;
            state_next = S_BURST;
          end else begin
            reject_c   = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_BURST: begin
        if (tick && (us_next == BURST_US)) begin
          load_echo_c = 1'b1;
          state_next  = S_ECHO;
        end
      end
      S_ECHO: begin
        if (tick && (us_next == echo_us)) begin
          state_next = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (tick && (us_next == HOLDOFF_US)) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Two-flop trigger synchronizer plus the delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
    end
  end

  // Timebase: restarts on every state entry so phases are whole microseconds.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if ((state_next != state) || (state == S_IDLE)) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (tick) begin
      presc <= '0;
      if (us_cnt != {UW{1'b1}}) begin
        us_cnt <= us_cnt + UW'(1);
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Distance latch and accepted-trigger counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dist_q     <= '0;
      trig_count <= '0;
    end else if (accept_c) begin
      dist_q     <= dist_cm;
      trig_count <= trig_count + 8'd1;
    end
  end

  // Echo width is frozen when the echo starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_us <= '0;
    end else if (load_echo_c) begin
      echo_us <= echo_width_c;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo       <= 1'b0;
      busy       <= 1'b0;
      short_trig <= 1'b0;
    end else begin
      echo       <= (state_next == S_ECHO);
      busy       <= (state_next != S_IDLE);
      short_trig <= reject_c;
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_model.sv
// Bench for ultrasonic_echo_model with shortened timing parameters.
module tb_ultrasonic_echo_model;

  localparam int unsigned CPU  = 2;
  localparam int unsigned MIN  = 10;
  localparam int unsigned BUS  = 3;
  localparam int unsigned UPC  = 3;
  localparam int unsigned DMAX = 400;
  localparam int unsigned MAXE = 1500;
  localparam int unsigned HOLD = 20;
  // Drop of trig to first echo-high sample: 2 sync flops, fall detect, burst.
  localparam int unsigned LAT  = BUS * CPU + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [15:0] dist_cm;
  logic        echo;
  logic        busy;
  logic [7:0]  trig_count;
  logic        short_trig;

  typedef struct {
    int unsigned width;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          short_seen = 0;
  logic [7:0]  cnt_model = 8'd0;

  always #5 clk = ~clk;

  ultrasonic_echo_model #(
    .CLK_PER_US (CPU),
    .MIN_TRIG_US(MIN),
    .BURST_US   (BUS),
    .US_PER_CM  (UPC),
    .DIST_MAX_CM(DMAX),
    .MAX_ECHO_US(MAXE),
    .HOLDOFF_US (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .dist_cm   (dist_cm),
    .echo      (echo),
    .busy      (busy),
    .trig_count(trig_count),
    .short_trig(short_trig)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned echo_cycles(input logic [15:0] d);
    if (d == 16'd0 || int'(d) > int'(DMAX)) return MAXE * CPU;
    return int'(d) * UPC * CPU;
  endfunction

  // Count short_trig pulse cycles.
  always @(negedge clk) begin
    if (short_trig === 1'b1) short_seen++;
  end

  // Echo monitor: measures each pulse and scores it against the queue.
  initial begin : mon
    int unsigned w;
    int unsigned h;
    logic [7:0]  c;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (echo === 1'b1) begin
        c = trig_count;
        w = 0;
        while (echo === 1'b1 && w < 20000) begin
          w++;
          @(negedge clk);
        end
        if (rst !== 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_echo", w, 0);
          end else begin
            e = sb.pop_front();
            chk("echo_width", w, e.width);
            chk("echo_count", c, e.cnt);
            h = 0;
            while (busy === 1'b1 && h < 10000) begin
              h++;
              @(negedge clk);
            end
            chk("busy_after_echo", h, HOLD * CPU);
          end
        end
      end
    end
  end

  // Issue one trigger and wait for the model to return to idle.
  task automatic pulse(input int unsigned us_hi, input logic [15:0] d,
                       input bit ok, input bit chg);
    int n;
    int s0;
    @(negedge clk);
    dist_cm = d;
    trig    = 1'b1;
    repeat (us_hi * CPU) @(negedge clk);
    trig = 1'b0;
    s0   = short_seen;
    if (ok) begin
      cnt_model = cnt_model + 8'd1;
      sb.push_back('{echo_cycles(d), cnt_model});
      n = 0;
      while (echo !== 1'b1 && n < int'(LAT) + 50) begin
        @(negedge clk);
        n++;
      end
      chk("echo_latency", n, LAT);
      if (chg) dist_cm = 16'd300;
    end
    n = 0;
    while (busy !== 1'b0 && n < int'(MAXE * CPU + HOLD * CPU) + 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
    @(negedge clk);
    chk(ok ? "no_short" : "short_pulse", short_seen - s0, ok ? 0 : 1);
    chk("trig_count", trig_count, cnt_model);
    chk("busy_idle", busy, 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int s0;
    rst     = 1'b1;
    trig    = 1'b0;
    dist_cm = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_echo", echo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", trig_count, 0);
    chk("rst_short", short_trig, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal range; distance changed mid-echo must not alter the width.
    pulse(12, 16'd10, 1'b1, 1'b1);
    // Too-short trigger is rejected.
    pulse(9, 16'd10, 1'b0, 1'b0);
    // Out-of-range and boundary distances.
    pulse(12, 16'd0, 1'b1, 1'b0);
    pulse(12, 16'd401, 1'b1, 1'b0);
    pulse(12, 16'd400, 1'b1, 1'b0);

    // Triggers during ECHO and HOLDOFF are ignored.
    @(negedge clk);
    dist_cm = 16'd20;
    trig    = 1'b1;
    repeat (12 * CPU) @(negedge clk);
    trig      = 1'b0;
    s0        = short_seen;
    cnt_model = cnt_model + 8'd1;
    sb.push_back('{echo_cycles(16'd20), cnt_model});
    n = 0;
    while (echo !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ign_echo_seen", echo, 1);
    repeat (4) @(negedge clk);
    trig = 1'b1;
    repeat (12 * CPU) @(negedge clk);
    trig = 1'b0;
    n = 0;
    while (echo !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    chk("ign_echo_done", echo, 0);
    trig = 1'b1;
    repeat (12 * CPU) @(negedge clk);
    trig = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("ign_count", trig_count, cnt_model);
    chk("ign_short", short_seen - s0, 0);
    pulse(12, 16'd5, 1'b1, 1'b0);

    // Reset in the middle of an echo.
    @(negedge clk);
    dist_cm = 16'd50;
    trig    = 1'b1;
    repeat (12 * CPU) @(negedge clk);
    trig = 1'b0;
    n = 0;
    while (echo !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("mid_echo_seen", echo, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_echo", echo, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", trig_count, 0);
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    cnt_model = 8'd0;
    repeat (2) @(negedge clk);

    // 256 accepted triggers wrap the counter back to zero.
    for (int i = 0; i < 256; i++) begin
      pulse(12, 16'(1 + (i % 4)), 1'b1, (i == 100));
    end
    chk("count_wrap", trig_count, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
